// File: rtl/cmn_counter_pkg.sv
// Shared definitions for the cmn counter family: bound-handling mode constants.
package cmn_counter_pkg;

  localparam int CMN_COUNTER_SATURATE = 0;
  localparam int CMN_COUNTER_WRAP     = 1;

endpackage : cmn_counter_pkg

// File: rtl/cmn_ResetReg.sv
// Generic register with synchronous active-high reset to a parameterised value.
module cmn_ResetReg #(
  parameter int                 p_nbits       = 1,
  parameter logic [p_nbits-1:0] p_reset_value = {p_nbits{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [p_nbits-1:0] d,
  output logic [p_nbits-1:0] q
);

  // State update: reset value on reset, otherwise capture d.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= p_reset_value;
    end else begin
      q <= d;
    end
  end

endmodule : cmn_ResetReg

// File: rtl/cmn_step_counter.sv
// Bounded up/down counter with variable step, wrap or saturate at [min,max],
// and registered one-cycle overflow/underflow pulses.
module cmn_step_counter
  import cmn_counter_pkg::*;
#(
  parameter int p_count_nbits       = 4,
  parameter int p_step_nbits        = 3,
  parameter int p_count_min_value   = 0,
  parameter int p_count_max_value   = 15,
  parameter int p_count_clear_value = 0,
  parameter int p_wrap              = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     load,
  input  logic [p_count_nbits-1:0] load_value,
  input  logic                     increment,
  input  logic                     decrement,
  input  logic [p_step_nbits-1:0]  step,
  output logic [p_count_nbits-1:0] count,
  output logic                     count_is_min,
  output logic                     count_is_max,
  output logic                     count_is_zero,
  output logic                     overflow,
  output logic                     underflow
);

  // Two guard bits keep count+step and count+span-step exact.
  localparam int                lp_w     = p_count_nbits + 2;
  localparam logic [lp_w-1:0]   lp_min   = lp_w'(p_count_min_value);
  localparam logic [lp_w-1:0]   lp_max   = lp_w'(p_count_max_value);
  localparam logic [lp_w-1:0]   lp_span  = lp_w'(p_count_max_value - p_count_min_value + 1);
  localparam logic [p_count_nbits-1:0] lp_clear = p_count_nbits'(p_count_clear_value);

  generate
    if ((p_count_min_value < 0) ||
        (p_count_max_value <= p_count_min_value) ||
        (p_count_max_value > (2 ** p_count_nbits) - 1) ||
        (p_count_clear_value < p_count_min_value) ||
        (p_count_clear_value > p_count_max_value) ||
        ((p_wrap != CMN_COUNTER_WRAP) && (p_wrap != CMN_COUNTER_SATURATE))) begin : g_param_check
      $error("cmn_step_counter: illegal parameter combination");
    end
  endgenerate

  logic [lp_w-1:0]          count_w_s;
  logic [lp_w-1:0]          load_w_s;
  logic [lp_w-1:0]          step_w_s;
  logic [lp_w-1:0]          eff_step_s;
  logic [lp_w-1:0]          sum_s;
  logic [lp_w-1:0]          dn_wrap_s;
  logic [lp_w-1:0]          dn_floor_s;
  logic [p_count_nbits-1:0] next_count_s;
  logic                     next_overflow_s;
  logic                     next_underflow_s;

  // Next-state selection: clear > load > step > hold (reset lives in the registers).
  always_comb begin
    count_w_s        = {2'b00, count};
    load_w_s         = {2'b00, load_value};
    step_w_s         = lp_w'(step);
    eff_step_s       = (step_w_s > lp_span) ? lp_span : step_w_s;
    sum_s            = count_w_s + eff_step_s;
    dn_wrap_s        = count_w_s + lp_span - eff_step_s;
    dn_floor_s       = lp_min + eff_step_s;
    next_count_s     = count;
    next_overflow_s  = 1'b0;
    next_underflow_s = 1'b0;
    if (clear) begin
      next_count_s = lp_clear;
    end else if (load) begin
      if (load_w_s < lp_min) begin
        next_count_s = p_count_nbits'(lp_min);
      end else if (load_w_s > lp_max) begin
        next_count_s = p_count_nbits'(lp_max);
      end else begin
        next_count_s = load_value;
      end
    end else if (increment && !decrement && (eff_step_s != {lp_w{1'b0}})) begin
      if (sum_s > lp_max) begin
        next_overflow_s = 1'b1;
        if (p_wrap == CMN_COUNTER_WRAP) begin
          next_count_s = p_count_nbits'(sum_s - lp_span);
        end else begin
          next_count_s = p_count_nbits'(lp_max);
        end
      end else begin
        next_count_s = p_count_nbits'(sum_s);
      end
    end else if (decrement && !increment && (eff_step_s != {lp_w{1'b0}})) begin
      // count - step < min rewritten as count < min + step to stay unsigned.
      if (count_w_s < dn_floor_s) begin
        next_underflow_s = 1'b1;
        if (p_wrap == CMN_COUNTER_WRAP) begin
          next_count_s = p_count_nbits'(dn_wrap_s);
        end else begin
          next_count_s = p_count_nbits'(lp_min);
        end
      end else begin
        next_count_s = p_count_nbits'(count_w_s - eff_step_s);
      end
    end else begin
      next_count_s = count;
    end
  end

  cmn_ResetReg #(
    .p_nbits       (p_count_nbits),
    .p_reset_value (lp_clear)
  ) u_count_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_count_s),
    .q     (count)
  );

  cmn_ResetReg #(
    .p_nbits       (1),
    .p_reset_value (1'b0)
  ) u_overflow_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_overflow_s),
    .q     (overflow)
  );

  cmn_ResetReg #(
    .p_nbits       (1),
    .p_reset_value (1'b0)
  ) u_underflow_reg (
    .clk   (clk),
    .reset (reset),
    .d     (next_underflow_s),
    .q     (underflow)
  );

  assign count_is_min  = ({2'b00, count} == lp_min);
  assign count_is_max  = ({2'b00, count} == lp_max);
  assign count_is_zero = (count == {p_count_nbits{1'b0}});

endmodule : cmn_step_counter

// File: tb/tb_cmn_step_counter.sv
// Bench for cmn_step_counter: a wrapping and a saturating instance share stimulus
// and are compared against an integer reference model of the counting rules.
module tb_cmn_step_counter;

  localparam int NB   = 4;
  localparam int SB   = 3;
  localparam int MIN  = 2;
  localparam int MAX  = 11;
  localparam int CLR  = 5;
  localparam int SPAN = MAX - MIN + 1;

  logic          clk = 1'b0;
  logic          reset, clear, load, increment, decrement;
  logic [NB-1:0] load_value;
  logic [SB-1:0] step;

  logic [NB-1:0] count_w, count_s;
  logic          is_min_w, is_max_w, is_zero_w, ovf_w, unf_w;
  logic          is_min_s, is_max_s, is_zero_s, ovf_s, unf_s;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt_w, m_ovf_w, m_unf_w;
  int m_cnt_s, m_ovf_s, m_unf_s;

  always #5 clk = ~clk;

  cmn_step_counter #(
    .p_count_nbits(NB), .p_step_nbits(SB), .p_count_min_value(MIN),
    .p_count_max_value(MAX), .p_count_clear_value(CLR), .p_wrap(1)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .increment(increment), .decrement(decrement), .step(step), .count(count_w),
    .count_is_min(is_min_w), .count_is_max(is_max_w), .count_is_zero(is_zero_w),
    .overflow(ovf_w), .underflow(unf_w)
  );

  cmn_step_counter #(
    .p_count_nbits(NB), .p_step_nbits(SB), .p_count_min_value(MIN),
    .p_count_max_value(MAX), .p_count_clear_value(CLR), .p_wrap(0)
  ) u_dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_value(load_value),
    .increment(increment), .decrement(decrement), .step(step), .count(count_s),
    .count_is_min(is_min_s), .count_is_max(is_max_s), .count_is_zero(is_zero_s),
    .overflow(ovf_s), .underflow(unf_s)
  );

  // Reference: next count and flags from the current inputs and modelled count.
  function automatic void ref_next(input int c, input int wr,
                                   output int nc, output int ov, output int un);
    int e;
    int lv;
    e  = (int'(step) > SPAN) ? SPAN : int'(step);
    lv = int'(load_value);
    nc = c;
    ov = 0;
    un = 0;
    if (reset || clear) begin
      nc = CLR;
    end else if (load) begin
      nc = (lv < MIN) ? MIN : ((lv > MAX) ? MAX : lv);
    end else if (increment && !decrement && e > 0) begin
      if (c + e > MAX) begin
        ov = 1;
        nc = wr ? (c + e - SPAN) : MAX;
      end else begin
        nc = c + e;
      end
    end else if (decrement && !increment && e > 0) begin
      if (c - e < MIN) begin
        un = 1;
        nc = wr ? (c - e + SPAN) : MIN;
      end else begin
        nc = c - e;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic r, input logic c, input logic l, input logic [NB-1:0] lv,
                      input logic inc, input logic dec, input logic [SB-1:0] st);
    int nw, ow, uw, ns, os, us;
    reset = r; clear = c; load = l; load_value = lv;
    increment = inc; decrement = dec; step = st;
    ref_next(m_cnt_w, 1, nw, ow, uw);
    ref_next(m_cnt_s, 0, ns, os, us);
    @(posedge clk);
    #1;
    m_cnt_w = nw; m_ovf_w = ow; m_unf_w = uw;
    m_cnt_s = ns; m_ovf_s = os; m_unf_s = us;
    check("wrap_count",     {28'd0, count_w},   m_cnt_w);
    check("wrap_overflow",  {31'd0, ovf_w},     m_ovf_w);
    check("wrap_underflow", {31'd0, unf_w},     m_unf_w);
    check("wrap_is_min",    {31'd0, is_min_w},  (m_cnt_w == MIN) ? 1 : 0);
    check("wrap_is_max",    {31'd0, is_max_w},  (m_cnt_w == MAX) ? 1 : 0);
    check("wrap_is_zero",   {31'd0, is_zero_w}, (m_cnt_w == 0) ? 1 : 0);
    check("sat_count",      {28'd0, count_s},   m_cnt_s);
    check("sat_overflow",   {31'd0, ovf_s},     m_ovf_s);
    check("sat_underflow",  {31'd0, unf_s},     m_unf_s);
    check("sat_is_min",     {31'd0, is_min_s},  (m_cnt_s == MIN) ? 1 : 0);
    check("sat_is_max",     {31'd0, is_max_s},  (m_cnt_s == MAX) ? 1 : 0);
    check("sat_is_zero",    {31'd0, is_zero_s}, (m_cnt_s == 0) ? 1 : 0);
  endtask

  initial begin
    m_cnt_w = CLR; m_ovf_w = 0; m_unf_w = 0;
    m_cnt_s = CLR; m_ovf_s = 0; m_unf_s = 0;

    // Reset with an increment pending: reset wins.
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd3);
    check("reset_count_literal", {28'd0, count_w}, 32'd5);
    tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd3);
    // First command after reset.
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd1);

    // Wrap over max: 10 + 3 -> 3 (wrap), 11 (sat); pulse lasts one cycle.
    tick(1'b0, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd3);
    check("wrap_over_literal", {28'd0, count_w}, 32'd3);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 3'd3);

    // Saturate: 9 + 4 -> 11, then again at max.
    tick(1'b0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd4);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd4);
    check("sat_repeat_literal", {31'd0, ovf_s}, 32'd1);

    // Below min: 3 - 2 -> 11 (wrap), 2 (sat); then at min again.
    tick(1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd2);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd2);

    // Load clamps above max and below min, beating inc/dec.
    tick(1'b0, 1'b0, 1'b1, 4'd14, 1'b1, 1'b1, 3'd5);
    tick(1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 3'd0);
    check("load_clamp_min_literal", {28'd0, count_s}, 32'd2);

    // Both directions hold; step 0 holds; clear beats increment; mid-run reset.
    tick(1'b0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 3'd5);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd0);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 3'd0);
    tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 3'd3);
    tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 3'd7);
    tick(1'b1, 1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 3'd7);

    // Randomised traffic with occasional reset/clear/load.
    for (int i = 0; i < 400; i++) begin
      tick(($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cmn_step_counter
